// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-enable divider.
package clk_div_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // The high phase of the square wave lasts floor(d/2) cycles.
  function automatic logic [31:0] half_div(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: counts 0 .. active_div-1 and flags the last cycle of each period.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] active_div,
  output logic [DIV_W-1:0] cnt,
  output logic [DIV_W-1:0] cnt_next,
  output logic             wrap
);

  // active_div is never below 2, so the subtraction cannot underflow.
  assign wrap = (cnt == (active_div - DIV_W'(1)));

  // NOTE: give every combinational output a default first so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = wrap ? '0 : cnt + DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/clk_div_controller.sv
// Start/stop sequencer producing a tick and a square-wave enable with a ready/valid ratio port.
// Optional tick counter output enabled by defining CLK_DIV_TICK_COUNT_EN.
module clk_div_controller
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             running,
  output logic             tick,
  output logic             clk_en_sq,
  output logic [DIV_W-1:0] active_div
`ifdef CLK_DIV_TICK_COUNT_EN
  ,
  output logic [31:0]      tick_count
`endif
);

  state_t           state, state_next;
  logic [DIV_W-1:0] active_div_next;
  logic [DIV_W-1:0] shadow, shadow_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic             wrap;
  logic             cnt_clear;
  logic             leave_idle;
  logic             cfg_offer;
  logic             accept;
  logic             clk_en_next;

  assign running   = (state != IDLE);
  assign cfg_ready = (state != PEND);
  assign tick      = running && wrap;

  assign cfg_offer = cfg_valid && cfg_ready;
  assign accept    = cfg_offer && (cfg_div >= DIV_W'(MIN_DIV));

  clk_div_counter #(
    .DIV_W (DIV_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .enable     (running),
    .clear      (cnt_clear),
    .active_div (active_div),
    .cnt        (cnt),
    .cnt_next   (cnt_next),
    .wrap       (wrap)
  );

  always_comb begin
    state_next      = state;
    active_div_next = active_div;
    shadow_next     = shadow;
    cnt_clear       = 1'b0;
    leave_idle      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (accept) active_div_next = cfg_div;
        if (start && !stop) begin
          state_next = RUN;
          leave_idle = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
          if (accept) active_div_next = cfg_div;
        end else if (accept) begin
          // On the wrap cycle the new ratio can start cleanly at the next cnt=0.
          if (wrap) begin
            active_div_next = cfg_div;
          end else begin
            shadow_next = cfg_div;
            state_next  = PEND;
          end
        end
      end
      PEND: begin
        if (stop) begin
          state_next      = IDLE;
          cnt_clear       = 1'b1;
          active_div_next = shadow;
        end else if (wrap) begin
          state_next      = RUN;
          active_div_next = shadow;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Evaluated on next-cycle values so the enable lines up with cnt and the ratio in use.
  assign clk_en_next = (state_next != IDLE) &&
                       (cnt_next < DIV_W'(half_div(32'(active_div_next))));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      active_div <= DIV_W'(DEFAULT_DIV);
      shadow     <= '0;
      clk_en_sq  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_next;
      active_div <= active_div_next;
      shadow     <= shadow_next;
      clk_en_sq  <= clk_en_next;
      cfg_err    <= cfg_offer && !accept;
    end
  end

`ifdef CLK_DIV_TICK_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || leave_idle) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= tick_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_controller.sv
// Directed self-checking bench for clk_div_controller with hand-computed expectations.
module tb_clk_div_controller;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             running;
  logic             tick;
  logic             clk_en_sq;
  logic [DIV_W-1:0] active_div;
`ifdef CLK_DIV_TICK_COUNT_EN
  logic [31:0]      tick_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  clk_div_controller #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .running    (running),
    .tick       (tick),
    .clk_en_sq  (clk_en_sq),
    .active_div (active_div)
`ifdef CLK_DIV_TICK_COUNT_EN
    ,
    .tick_count (tick_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".running"},    32'(running),    0);
    check({tag, ".tick"},       32'(tick),       0);
    check({tag, ".clk_en_sq"},  32'(clk_en_sq),  0);
    check({tag, ".cfg_ready"},  32'(cfg_ready),  1);
    check({tag, ".cfg_err"},    32'(cfg_err),    0);
    check({tag, ".active_div"}, 32'(active_div), 2);
`ifdef CLK_DIV_TICK_COUNT_EN
    check({tag, ".tick_count"}, tick_count, 0);
`endif
  endtask

  task automatic offer_idle_cfg(input int d);
    cfg_valid = 1'b1;
    cfg_div   = DIV_W'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    step();
    check_reset_values("rst");

    // Default divide-by-2: running from cycle 1, tick on every second cycle.
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check("div2.running", 32'(running),   1);
      check("div2.tick",    32'(tick),      32'(j % 2 == 1));
      check("div2.en",      32'(clk_en_sq), 32'(j % 2 == 0));
      check("div2.div",     32'(active_div), 2);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop1.running", 32'(running),   0);
    check("stop1.en",      32'(clk_en_sq), 0);

    // Ratio 5 programmed in IDLE: high 2 cycles, low 3, tick on cnt=4.
    offer_idle_cfg(5);
    check("idle5.div",     32'(active_div), 5);
    check("idle5.running", 32'(running),    0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check("div5.tick", 32'(tick),      32'(j % 5 == 4));
      check("div5.en",   32'(clk_en_sq), 32'(j % 5 < 2));
      step();
    end
`ifdef CLK_DIV_TICK_COUNT_EN
    check("div5.tick_count", tick_count, 2);
`endif
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Ratio 4 running, new ratio 10 accepted at cnt=1, applied at the wrap.
    offer_idle_cfg(4);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    cfg_valid = 1'b1;
    cfg_div   = 16'd10;
    check("pend.ready_before", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    check("pend.c2.ready", 32'(cfg_ready),  0);
    check("pend.c2.div",   32'(active_div), 4);
    check("pend.c2.tick",  32'(tick),       0);
    check("pend.c2.run",   32'(running),    1);
    step();
    check("pend.c3.ready", 32'(cfg_ready),  0);
    check("pend.c3.div",   32'(active_div), 4);
    check("pend.c3.tick",  32'(tick),       1);
    step();
    check("pend.apply.ready", 32'(cfg_ready),  1);
    check("pend.apply.div",   32'(active_div), 10);
    for (int j = 0; j < 10; j++) begin
      check("div10.tick", 32'(tick),      32'(j == 9));
      check("div10.en",   32'(clk_en_sq), 32'(j < 5));
      step();
    end

    // Offer on the wrap cycle of ratio 10: new ratio 3 starts at next cnt=0, no PEND.
    for (int j = 0; j < 9; j++) step();
    check("wrapcfg.tick", 32'(tick), 1);
    cfg_valid = 1'b1;
    cfg_div   = 16'd3;
    step();
    cfg_valid = 1'b0;
    check("wrapcfg.div",   32'(active_div), 3);
    check("wrapcfg.ready", 32'(cfg_ready),  1);
    for (int j = 0; j < 6; j++) begin
      check("div3.tick", 32'(tick),      32'(j % 3 == 2));
      check("div3.en",   32'(clk_en_sq), 32'(j % 3 < 1));
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Illegal ratios are rejected with a one-cycle error pulse.
    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    step();
    check("err1.pulse", 32'(cfg_err),    1);
    check("err1.div",   32'(active_div), 3);
    cfg_div = 16'd0;
    step();
    cfg_valid = 1'b0;
    check("err0.pulse", 32'(cfg_err),    1);
    check("err0.div",   32'(active_div), 3);
    step();
    check("err.clear",  32'(cfg_err),    0);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = 16'd1;
    step();
    cfg_valid = 1'b0;
    check("errrun.pulse", 32'(cfg_err),    1);
    check("errrun.ready", 32'(cfg_ready),  1);
    check("errrun.div",   32'(active_div), 3);
    step();
    check("errrun.clear", 32'(cfg_err),    0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Stop while PEND commits the shadow ratio.
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_div   = 16'd7;
    step();
    cfg_valid = 1'b0;
    check("stoppend.ready", 32'(cfg_ready), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stoppend.running", 32'(running),    0);
    check("stoppend.tick",    32'(tick),       0);
    check("stoppend.en",      32'(clk_en_sq),  0);
    check("stoppend.div",     32'(active_div), 7);
    check("stoppend.ready2",  32'(cfg_ready),  1);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("startstop.running", 32'(running), 0);
    step();
    check("startstop.running2", 32'(running), 0);

    // Reset mid-period at ratio 6, cnt=3.
    offer_idle_cfg(6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("div6.c3.en",   32'(clk_en_sq), 0);
    check("div6.c3.tick", 32'(tick),      0);
    check("div6.c3.div",  32'(active_div), 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_values("midrst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
